// File: rtl/xor8_descrambler.sv
// Byte-wide XOR descrambler: strips an 8-bit Galois LFSR keystream from a scrambled
// byte stream, with valid/ready on both sides and a one-entry output register.
module xor8_descrambler #(
    parameter int unsigned     WIDTH        = 8,
    parameter logic [WIDTH-1:0] POLY         = 8'hB8,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = 8'h01
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_seed_load,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in1,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out,
    output logic             o_seed_err,
    output logic [15:0]      o_byte_cnt
);

    // state | meaning
    // IDLE  | after reset, no keystream alignment yet; input blocked
    // RUN   | streaming; left only through reset
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_ks;
    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;
    logic             r_seed_err;
    logic [15:0]      r_byte_cnt;

    logic             w_accept;
    logic             w_seed_zero;
    logic [WIDTH-1:0] w_ks_step;

    assign w_seed_zero = (i_seed == '0);
    assign w_ks_step   = (r_ks >> 1) ^ (r_ks[0] ? POLY : '0);

    // seed_load blocks acceptance so the keystream is never stepped and reloaded together
    assign o_in_ready = (r_state == S_RUN) && !i_seed_load && (!r_out_valid || i_out_ready);
    assign w_accept   = i_in_valid && o_in_ready;

    always_comb begin
        w_state_nxt = r_state;
        if (i_seed_load) begin
            w_state_nxt = S_RUN;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ks       <= SEED_DEFAULT;
            r_seed_err <= 1'b0;
            r_byte_cnt <= 16'h0000;
        end else begin
            r_seed_err <= i_seed_load && w_seed_zero;
            if (i_seed_load) begin
                r_ks       <= w_seed_zero ? SEED_DEFAULT : i_seed;
                r_byte_cnt <= 16'h0000;
            end else if (w_accept) begin
                r_ks       <= w_ks_step;
                r_byte_cnt <= r_byte_cnt + 16'h0001;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out       <= i_in1 ^ r_ks;
            r_out_valid <= 1'b1;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out       = r_out;
    assign o_seed_err  = r_seed_err;
    assign o_byte_cnt  = r_byte_cnt;

endmodule

// File: tb/tb_xor8_descrambler.sv
// Directed bench for xor8_descrambler: a byte-indexed keystream model checked every
// cycle, plus literal expectations taken from hand-computed descrambled bytes.
module tb_xor8_descrambler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        seed_load = 1'b0;
    logic [7:0]  seed = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in1 = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_b;
    logic        seed_err;
    logic [15:0] byte_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    xor8_descrambler dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_seed_load (seed_load),
        .i_seed      (seed),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in1       (in1),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out       (out_b),
        .o_seed_err  (seed_err),
        .o_byte_cnt  (byte_cnt)
    );

    always #5 clk = ~clk;

    // Keystream value for byte number n after loading seed s
    function automatic logic [7:0] keystream(input logic [7:0] s, input int n);
        logic [7:0] k;
        k = s;
        for (int i = 0; i < n; i++) begin
            k = {1'b0, k[7:1]} ^ (k[0] ? 8'hB8 : 8'h00);
        end
        return k;
    endfunction

    logic       m_run   = 1'b0;
    logic [7:0] m_seed  = 8'h01;
    int         m_n     = 0;
    logic [7:0] m_out   = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_err   = 1'b0;

    always @(posedge clk or posedge rst) begin
        logic acc;
        if (rst) begin
            m_run = 1'b0; m_seed = 8'h01; m_n = 0;
            m_out = 8'h00; m_valid = 1'b0; m_err = 1'b0;
        end else begin
            acc = m_run && !seed_load && (!m_valid || out_ready) && in_valid;
            if (acc) begin
                m_out   = in1 ^ keystream(m_seed, m_n);
                m_valid = 1'b1;
                m_n     = m_n + 1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            m_err = seed_load && (seed == 8'h00);
            if (seed_load) begin
                m_run  = 1'b1;
                m_seed = (seed == 8'h00) ? 8'h01 : seed;
                m_n    = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_in_ready", {15'd0, in_ready},
                {15'd0, m_run && !seed_load && (!m_valid || out_ready)});
            chk("m_out_valid", {15'd0, out_valid}, {15'd0, m_valid});
            if (m_valid) chk("m_out", {8'd0, out_b}, {8'd0, m_out});
            chk("m_seed_err", {15'd0, seed_err}, {15'd0, m_err});
            chk("m_byte_cnt", byte_cnt, m_n[15:0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] s);
        seed_load = 1'b1; seed = s;
        tick();
        seed_load = 1'b0;
    endtask

    logic [7:0] t1_in  [4] = '{8'h33, 8'hCC, 8'hAA, 8'hF0};
    logic [7:0] t1_exp [4] = '{8'h32, 8'h74, 8'hF6, 8'hDE};

    initial begin
        #1 rst = 1'b1;
        tick(); tick();
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out", {8'd0, out_b}, 16'd0);
        chk("rst_byte_cnt", byte_cnt, 16'd0);
        chk("rst_seed_err", {15'd0, seed_err}, 16'd0);
        chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
        rst = 1'b0;

        // idle: offered bytes are refused
        in_valid = 1'b1; in1 = 8'h55; out_ready = 1'b1;
        tick(); tick(); tick();
        chk("idle_in_ready", {15'd0, in_ready}, 16'd0);
        chk("idle_out_valid", {15'd0, out_valid}, 16'd0);
        chk("idle_byte_cnt", byte_cnt, 16'd0);
        in_valid = 1'b0;

        // full-rate stream
        load(8'h01);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in1 = t1_in[i];
            tick();
            chk("t1_out_valid", {15'd0, out_valid}, 16'd1);
            chk("t1_out", {8'd0, out_b}, {8'd0, t1_exp[i]});
        end
        chk("t1_byte_cnt", byte_cnt, 16'd4);
        in_valid = 1'b0;
        tick();
        chk("t1_drained", {15'd0, out_valid}, 16'd0);

        // output stall holds data and keystream
        load(8'h01);
        in_valid = 1'b1; in1 = 8'h33;
        tick();
        chk("t3_first", {8'd0, out_b}, 16'h0032);
        out_ready = 1'b0; in1 = 8'hCC;
        tick(); tick();
        chk("t3_stall_ready", {15'd0, in_ready}, 16'd0);
        chk("t3_stall_out", {8'd0, out_b}, 16'h0032);
        chk("t3_stall_valid", {15'd0, out_valid}, 16'd1);
        out_ready = 1'b1;
        tick();
        chk("t3_resume", {8'd0, out_b}, 16'h0074);
        in_valid = 1'b0;
        tick();

        // zero seed substitutes the default and flags once
        seed_load = 1'b1; seed = 8'h00;
        tick();
        chk("t4_err_pulse", {15'd0, seed_err}, 16'd1);
        seed_load = 1'b0;
        tick();
        chk("t4_err_clear", {15'd0, seed_err}, 16'd0);
        in_valid = 1'b1; in1 = 8'h33;
        tick();
        chk("t4_out", {8'd0, out_b}, 16'h0032);
        in_valid = 1'b0;
        tick();

        // back-to-back loads: the last seed wins
        seed_load = 1'b1; seed = 8'h5C;
        tick();
        seed = 8'h01;
        tick();
        seed_load = 1'b0;
        in_valid = 1'b1; in1 = 8'h33;
        tick();
        chk("b2b_out", {8'd0, out_b}, 16'h0032);
        in_valid = 1'b0;
        tick();

        // seed_load beats in_valid
        seed_load = 1'b1; seed = 8'h01; in_valid = 1'b1; in1 = 8'hAA;
        tick();
        chk("t5_cnt", byte_cnt, 16'd0);
        chk("t5_no_accept", {15'd0, out_valid}, 16'd0);
        seed_load = 1'b0;
        tick();
        chk("t5_out", {8'd0, out_b}, 16'h00AB);
        chk("t5_cnt1", byte_cnt, 16'd1);
        in_valid = 1'b0;

        // asynchronous reset with a pending output
        #2 rst = 1'b1;
        #1;
        chk("t6_out_valid", {15'd0, out_valid}, 16'd0);
        chk("t6_out", {8'd0, out_b}, 16'd0);
        chk("t6_cnt", byte_cnt, 16'd0);
        tick();
        rst = 1'b0;
        in_valid = 1'b1; in1 = 8'h33;
        tick();
        chk("t6_idle_ready", {15'd0, in_ready}, 16'd0);
        chk("t6_idle_valid", {15'd0, out_valid}, 16'd0);
        in_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
